// File: rtl/md_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
// The EX stage drives the master side; md_unit implements the slave side.
interface md_unit_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, md_op, a, b, input busy, hi, lo);
    modport slave  (input start, md_op, a, b, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with private HI/LO and single-cycle MTHI/MTLO.
// Define MD_MADD_EN to add MADD/MADDU accumulation into {hi,lo}.
module md_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic     clk,
    input  logic     reset,
    md_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        sgn_q;
`ifdef MD_MADD_EN
    logic        madd_q;
`endif

    logic        is_mul_op;
    logic        is_div_op;
    logic        last;
    logic        load_mul;
    logic        load_div;
    logic        mthi_we;
    logic        mtlo_we;
    logic        commit;
    logic        commit_we;

    logic        sx;
    logic        sy;
    logic [63:0] prod;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [63:0] result;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        is_div_op = (bus.md_op == 3'd2) || (bus.md_op == 3'd3);
`ifdef MD_MADD_EN
        is_mul_op = (bus.md_op == 3'd0) || (bus.md_op == 3'd1) ||
                    (bus.md_op == 3'd6) || (bus.md_op == 3'd7);
`else
        is_mul_op = (bus.md_op == 3'd0) || (bus.md_op == 3'd1);
`endif
        last       = (cnt == 4'd1);
        state_next = state;
        case (state)
            S_IDLE: begin
                if (bus.start && is_mul_op) begin
                    state_next = S_MUL;
                end else if (bus.start && is_div_op) begin
                    state_next = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (last) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        load_mul  = (state == S_IDLE) && bus.start && is_mul_op;
        load_div  = (state == S_IDLE) && bus.start && is_div_op;
        mthi_we   = (state == S_IDLE) && bus.start && (bus.md_op == 3'd4);
        mtlo_we   = (state == S_IDLE) && bus.start && (bus.md_op == 3'd5);
        commit    = (state != S_IDLE) && last;
        // A divide by zero still occupies the full latency but never writes HI/LO.
        commit_we = commit && !((state == S_DIV) && (b_q == '0));
        bus.busy  = (state != S_IDLE);
        bus.hi    = hi_q;
        bus.lo    = lo_q;
    end

    // Sign-extending to 64 bits lets one unsigned multiplier serve both MULT and MULTU.
    always_comb begin
        sx     = sgn_q & a_q[31];
        sy     = sgn_q & b_q[31];
        prod   = {{32{sx}}, a_q} * {{32{sy}}, b_q};
        a_mag  = sx ? (-a_q) : a_q;
        b_mag  = sy ? (-b_q) : b_q;
        q_mag  = (b_mag == '0) ? '0 : (a_mag / b_mag);
        r_mag  = (b_mag == '0) ? '0 : (a_mag % b_mag);
        quo    = (sx ^ sy) ? (-q_mag) : q_mag;
        rem    = sx ? (-r_mag) : r_mag;
        if (state == S_DIV) begin
            result = {rem, quo};
`ifdef MD_MADD_EN
        end else if (madd_q) begin
            result = {hi_q, lo_q} + prod;
`endif
        end else begin
            result = prod;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
`ifdef MD_MADD_EN
            madd_q <= 1'b0;
`endif
        end else begin
            if (load_mul || load_div) begin
                a_q   <= bus.a;
                b_q   <= bus.b;
                sgn_q <= ~bus.md_op[0];
                cnt   <= load_mul ? 4'(MUL_CYCLES) : 4'(DIV_CYCLES);
`ifdef MD_MADD_EN
                madd_q <= bus.md_op[2];
`endif
            end else if (state != S_IDLE) begin
                cnt <= cnt - 4'd1;
            end
            if (commit_we) begin
                hi_q <= result[63:32];
                lo_q <= result[31:0];
            end
            if (mthi_we) begin
                hi_q <= bus.a;
            end
            if (mtlo_we) begin
                lo_q <= bus.a;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: expected HI/LO and busy length are queued at issue
// and compared when busy drops.
module tb_md_unit;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_unit_if bus_i ();

    md_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_i)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] x, y, h, l);
        logic signed [63:0] ps;
        logic [63:0]        pu;
        ps = $signed(x) * $signed(y);
        pu = {32'b0, x} * {32'b0, y};
        case (op)
            3'd0: return ps;
            3'd1: return pu;
            3'd2: begin
                if (y == 0) return {h, l};
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                return {32'($signed(x) % $signed(y)), 32'($signed(x) / $signed(y))};
            end
            3'd3: begin
                if (y == 0) return {h, l};
                return {x % y, x / y};
            end
            3'd6: return {h, l} + ps;
            3'd7: return {h, l} + pu;
            default: return {h, l};
        endcase
    endfunction

    // Called at a negedge; start is sampled at the next posedge, returns at the following negedge.
    task automatic issue(input logic [2:0] op, input logic [31:0] x, y);
        exp_t        e;
        logic [63:0] r;
        r = model(op, x, y, exp_hi, exp_lo);
        e.hi = r[63:32];
        e.lo = r[31:0];
        case (op)
            3'd0, 3'd1: begin e.cycles = MUL_N; sb.push_back(e); exp_hi = e.hi; exp_lo = e.lo; end
            3'd2, 3'd3: begin e.cycles = DIV_N; sb.push_back(e); exp_hi = e.hi; exp_lo = e.lo; end
            3'd4: exp_hi = x;
            3'd5: exp_lo = x;
            default: begin
`ifdef MD_MADD_EN
                e.cycles = MUL_N; sb.push_back(e); exp_hi = e.hi; exp_lo = e.lo;
`endif
            end
        endcase
        bus_i.start = 1'b1;
        bus_i.md_op = op;
        bus_i.a     = x;
        bus_i.b     = y;
        @(negedge clk);
        bus_i.start = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && (sb.size() != 0 || bus_i.busy); i++) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (bus_i.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus_i.busy); end
        total++; if (bus_i.hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=00000000", bus_i.hi); end
        total++; if (bus_i.lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=00000000", bus_i.lo); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        logic [31:0] x, y;
        issue(3'd0, 32'hFFFFFFFE, 32'd3);
        wait_drain();
        total++; if (bus_i.hi !== 32'hFFFFFFFF || bus_i.lo !== 32'hFFFFFFFA) begin
            bad++; $display("FAIL mult_const got=%h_%h exp=ffffffff_fffffffa", bus_i.hi, bus_i.lo); end
        issue(3'd1, 32'hFFFFFFFE, 32'd3);
        wait_drain();
        total++; if (bus_i.hi !== 32'h00000002 || bus_i.lo !== 32'hFFFFFFFA) begin
            bad++; $display("FAIL multu_const got=%h_%h exp=00000002_fffffffa", bus_i.hi, bus_i.lo); end
        for (int i = 0; i < 4; i++) begin
            x = $urandom;
            y = $urandom;
            issue(3'(i % 2), x, y);
            wait_drain();
        end
    endtask

    task automatic test_div();
        logic [31:0] x, y;
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_drain();
        total++; if (bus_i.lo !== 32'hFFFFFFFD || bus_i.hi !== 32'hFFFFFFFF) begin
            bad++; $display("FAIL div_neg got hi=%h lo=%h exp hi=ffffffff lo=fffffffd", bus_i.hi, bus_i.lo); end
        issue(3'd3, 32'd7, 32'd2);
        wait_drain();
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_drain();
        total++; if (bus_i.lo !== 32'h80000000 || bus_i.hi !== 32'h0) begin
            bad++; $display("FAIL div_ovf got hi=%h lo=%h exp hi=00000000 lo=80000000", bus_i.hi, bus_i.lo); end
        for (int i = 0; i < 4; i++) begin
            x = $urandom;
            y = $urandom_range(1, 70000);
            if (i == 1) y = 32'hFFFFFFF3;
            issue(3'(2 + (i % 2)), x, y);
            wait_drain();
        end
    endtask

    task automatic test_div_zero();
        issue(3'd4, 32'h00001234, 32'd0);
        total++; if (bus_i.hi !== 32'h00001234 || bus_i.busy !== 1'b0) begin
            bad++; $display("FAIL mthi got hi=%h busy=%b exp hi=00001234 busy=0", bus_i.hi, bus_i.busy); end
        issue(3'd3, 32'd99, 32'd0);
        wait_drain();
        total++; if (bus_i.hi !== 32'h00001234) begin
            bad++; $display("FAIL divzero_hi got=%h exp=00001234", bus_i.hi); end
    endtask

    task automatic test_mtlo();
        issue(3'd5, 32'hDEADBEEF, 32'd0);
        total++; if (bus_i.lo !== 32'hDEADBEEF || bus_i.busy !== 1'b0) begin
            bad++; $display("FAIL mtlo got lo=%h busy=%b exp lo=deadbeef busy=0", bus_i.lo, bus_i.busy); end
    endtask

    task automatic test_ignore_busy();
        issue(3'd3, 32'd1000, 32'd3);
        repeat (2) @(negedge clk);
        bus_i.start = 1'b1;
        bus_i.md_op = 3'd0;
        bus_i.a     = 32'd5;
        bus_i.b     = 32'd6;
        @(negedge clk);
        bus_i.start = 1'b0;
        wait_drain();
        total++; if (bus_i.lo !== 32'd333 || bus_i.hi !== 32'd1) begin
            bad++; $display("FAIL ignore_busy got hi=%h lo=%h exp hi=00000001 lo=0000014d", bus_i.hi, bus_i.lo); end
    endtask

    task automatic test_back_to_back();
        issue(3'd0, 32'd1234, 32'd5678);
        for (int i = 0; i < 30 && bus_i.busy; i++) @(negedge clk);
        issue(3'd3, 32'd100, 32'd9);
        wait_drain();
    endtask

    task automatic test_reset_mid_div();
        int seen;
        issue(3'd2, 32'd100, 32'd7);
        sb.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_hi = '0;
        exp_lo = '0;
        total++; if (bus_i.busy !== 1'b0 || bus_i.hi !== 32'h0 || bus_i.lo !== 32'h0) begin
            bad++; $display("FAIL reset_mid got busy=%b hi=%h lo=%h exp 0/0/0", bus_i.busy, bus_i.hi, bus_i.lo); end
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus_i.busy || bus_i.hi != 0 || bus_i.lo != 0) seen++;
        end
        total++; if (seen !== 0) begin
            bad++; $display("FAIL late_commit got=%0d nonzero cycles exp=0", seen); end
    endtask

    task automatic test_madd();
        int busy_seen;
        issue(3'd4, 32'h0, 32'd0);
        issue(3'd5, 32'hFFFFFFFF, 32'd0);
        busy_seen = 0;
        issue(3'd7, 32'd1, 32'd1);
`ifdef MD_MADD_EN
        wait_drain();
        total++; if (bus_i.hi !== 32'd1 || bus_i.lo !== 32'd0) begin
            bad++; $display("FAIL maddu got=%h_%h exp=00000001_00000000", bus_i.hi, bus_i.lo); end
`else
        for (int i = 0; i < 6; i++) begin
            if (bus_i.busy) busy_seen++;
            @(negedge clk);
        end
        total++; if (busy_seen !== 0 || bus_i.hi !== 32'h0 || bus_i.lo !== 32'hFFFFFFFF) begin
            bad++; $display("FAIL madd_off got busy_cycles=%0d hi=%h lo=%h exp 0/00000000/ffffffff",
                            busy_seen, bus_i.hi, bus_i.lo); end
`endif
    endtask

    initial begin
        reset       = 1'b1;
        bus_i.start = 1'b0;
        bus_i.md_op = 3'd0;
        bus_i.a     = '0;
        bus_i.b     = '0;

        fork
            begin : monitor
                int   run;
                exp_t e;
                run = 0;
                forever begin
                    @(negedge clk);
                    #1;
                    if (reset) begin
                        run = 0;
                    end else if (bus_i.busy) begin
                        run++;
                    end else if (run > 0) begin
                        if (sb.size() == 0) begin
                            total++; bad++;
                            $display("FAIL unexpected_done busy_cycles=%0d required=no completion", run);
                        end else begin
                            e = sb.pop_front();
                            total++; if (run !== e.cycles) begin
                                bad++; $display("FAIL busy_len got=%0d exp=%0d", run, e.cycles); end
                            total++; if (bus_i.hi !== e.hi) begin
                                bad++; $display("FAIL sb_hi got=%h exp=%h", bus_i.hi, e.hi); end
                            total++; if (bus_i.lo !== e.lo) begin
                                bad++; $display("FAIL sb_lo got=%h exp=%h", bus_i.lo, e.lo); end
                        end
                        run = 0;
                    end
                end
            end
        join_none

        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_mtlo();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_div();
        test_madd();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
